// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Multi-cycle control FSM for the tiny RISC-V core. It runs one instruction
//   at a time through FETCH -> DECODE -> EXECUTE -> WRITEBACK. It issues fetches
//   over a request/ack handshake, latches the returned instruction, drives the
//   PC unit's advance/branch controls and the register-file write strobe, and
//   traps misaligned-PC and fetch-timeout faults.
//
// Optional build macro: FETCH_SEQUENCER_INSTRET_EN
//   When defined, adds a 64-bit retired-instruction counter output (instret).
//
// Parameters
//   FETCH_TIMEOUT  cycles allowed in FETCH without fetch_ack (0 = no timeout)
//   TIMEOUT_WIDTH  timeout counter width, 2**TIMEOUT_WIDTH > FETCH_TIMEOUT
//
// Ports
//   clock, reset            core clock, asynchronous active-high reset
//   run                     1 = keep issuing, 0 = stop at instruction boundary
//   program_counter         current PC from the PC unit
//   fetch_request/address   fetch handshake request and address
//   fetch_ack/data          memory response and instruction word
//   instruction             latched instruction register
//   instruction_valid       one-cycle pulse in DECODE
//   execute_done            execute unit finished
//   branch_taken            branch outcome, sampled with execute_done
//   register_write          rd write request, sampled with execute_done
//   pc_advance, pc_branch   PC update strobe and PC+offset select
//   register_write_enable   register-file write strobe in WRITEBACK
//   halted                  high while idle
//   fault, fault_cause      sticky fault flag and cause (01 misaligned, 10 timeout)
//   instret                 retired-instruction count (optional)
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int FETCH_TIMEOUT = 16,
  parameter int TIMEOUT_WIDTH = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] program_counter,
  output logic        fetch_request,
  output logic [31:0] fetch_address,
  input  logic        fetch_ack,
  input  logic [31:0] fetch_data,
  output logic [31:0] instruction,
  output logic        instruction_valid,
  input  logic        execute_done,
  input  logic        branch_taken,
  input  logic        register_write,
  output logic        pc_advance,
  output logic        pc_branch,
  output logic        register_write_enable,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  fault_cause
`ifdef FETCH_SEQUENCER_INSTRET_EN
  ,
  output logic [63:0] instret
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXECUTE,
    WRITEBACK,
    FAULT
  } state_t;

  localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT    = 2'b10;
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LIMIT = TIMEOUT_WIDTH'(FETCH_TIMEOUT - 1);

  state_t                   state;
  state_t                   next_state;
  logic [TIMEOUT_WIDTH-1:0] timeout_count;
  logic                     branch_taken_latched;
  logic                     register_write_latched;
  logic                     load_instruction;
  logic                     latch_execute;
  logic                     set_cause;
  logic [1:0]               next_cause;
  logic                     pc_misaligned;
  logic                     timeout_hit;

  assign pc_misaligned = (program_counter[1:0] != 2'b00);
  assign timeout_hit   = (FETCH_TIMEOUT != 0) && (timeout_count == TIMEOUT_LIMIT);
  assign fetch_address = fetch_request ? program_counter : 32'd0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state            = state;
    fetch_request         = 1'b0;
    instruction_valid     = 1'b0;
    pc_advance            = 1'b0;
    pc_branch             = 1'b0;
    register_write_enable = 1'b0;
    halted                = 1'b0;
    fault                 = 1'b0;
    load_instruction      = 1'b0;
    latch_execute         = 1'b0;
    set_cause             = 1'b0;
    next_cause            = 2'b00;
    case (state)
      IDLE: begin
        halted = 1'b1;
        if (run) begin
          if (pc_misaligned) begin
            next_state = FAULT;
            set_cause  = 1'b1;
            next_cause = CAUSE_MISALIGNED;
          end else begin
            next_state = FETCH;
          end
        end
      end
      FETCH: begin
        // The PC unit only updates at the end of WRITEBACK, so a misaligned
        // target from a branch is first visible here; suppress the request.
        if (pc_misaligned) begin
          next_state = FAULT;
          set_cause  = 1'b1;
          next_cause = CAUSE_MISALIGNED;
        end else begin
          fetch_request = 1'b1;
          if (fetch_ack) begin
            load_instruction = 1'b1;
            next_state       = DECODE;
          end else if (timeout_hit) begin
            next_state = FAULT;
            set_cause  = 1'b1;
            next_cause = CAUSE_TIMEOUT;
          end
        end
      end
      DECODE: begin
        instruction_valid = 1'b1;
        next_state        = EXECUTE;
      end
      EXECUTE: begin
        if (execute_done) begin
          latch_execute = 1'b1;
          next_state    = WRITEBACK;
        end
      end
      WRITEBACK: begin
        pc_advance            = 1'b1;
        pc_branch             = branch_taken_latched;
        register_write_enable = register_write_latched;
        next_state            = run ? FETCH : IDLE;
      end
      FAULT: begin
        fault = 1'b1;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instruction            <= 32'd0;
      timeout_count          <= '0;
      branch_taken_latched   <= 1'b0;
      register_write_latched <= 1'b0;
      fault_cause            <= 2'b00;
    end else begin
      if (load_instruction) instruction <= fetch_data;
      // Counts cycles of an outstanding request; cleared by ack or by leaving FETCH.
      if (fetch_request && !fetch_ack) timeout_count <= timeout_count + TIMEOUT_WIDTH'(1);
      else                             timeout_count <= '0;
      if (latch_execute) begin
        branch_taken_latched   <= branch_taken;
        register_write_latched <= register_write;
      end
      if (set_cause) fault_cause <= next_cause;
    end
  end

`ifdef FETCH_SEQUENCER_INSTRET_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)           instret <= 64'd0;
    else if (pc_advance) instret <= instret + 64'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//   Self-checking bench for fetch_sequencer. Each instruction is described by
//   its fetch wait, execute wait, branch/write outcome, data and branch offset;
//   the expected outputs for every cycle follow from the instruction timeline
//   (fetch cycles, one decode cycle, execute cycles, one writeback cycle).
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;
  localparam int TO = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic [31:0] program_counter;
  logic        fetch_request;
  logic [31:0] fetch_address;
  logic        fetch_ack;
  logic [31:0] fetch_data;
  logic [31:0] instruction;
  logic        instruction_valid;
  logic        execute_done;
  logic        branch_taken;
  logic        register_write;
  logic        pc_advance;
  logic        pc_branch;
  logic        register_write_enable;
  logic        halted;
  logic        fault;
  logic [1:0]  fault_cause;
`ifdef FETCH_SEQUENCER_INSTRET_EN
  logic [63:0] instret;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] pc;
  logic [31:0] instr_m;
  logic [63:0] retired;

  always #5 clock = ~clock;

  fetch_sequencer #(.FETCH_TIMEOUT(TO), .TIMEOUT_WIDTH(5)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .run                   (run),
    .program_counter       (program_counter),
    .fetch_request         (fetch_request),
    .fetch_address         (fetch_address),
    .fetch_ack             (fetch_ack),
    .fetch_data            (fetch_data),
    .instruction           (instruction),
    .instruction_valid     (instruction_valid),
    .execute_done          (execute_done),
    .branch_taken          (branch_taken),
    .register_write        (register_write),
    .pc_advance            (pc_advance),
    .pc_branch             (pc_branch),
    .register_write_enable (register_write_enable),
    .halted                (halted),
    .fault                 (fault),
    .fault_cause           (fault_cause)
`ifdef FETCH_SEQUENCER_INSTRET_EN
    ,
    .instret               (instret)
`endif
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic junk_inputs();
    fetch_ack      = 1'($urandom_range(0, 1));
    fetch_data     = $urandom;
    execute_done   = 1'($urandom_range(0, 1));
    branch_taken   = 1'($urandom_range(0, 1));
    register_write = 1'($urandom_range(0, 1));
  endtask

  // Outputs while no instruction is in flight (IDLE or FAULT).
  task automatic check_static(input string tag, input bit exp_halt, input bit exp_fault,
                              input logic [1:0] exp_cause);
    check_eq({tag, "/req"},   fetch_request, 0);
    check_eq({tag, "/addr"},  fetch_address, 0);
    check_eq({tag, "/ivld"},  instruction_valid, 0);
    check_eq({tag, "/adv"},   pc_advance, 0);
    check_eq({tag, "/br"},    pc_branch, 0);
    check_eq({tag, "/rwe"},   register_write_enable, 0);
    check_eq({tag, "/halt"},  halted, exp_halt);
    check_eq({tag, "/fault"}, fault, exp_fault);
    check_eq({tag, "/cause"}, fault_cause, exp_cause);
    check_eq({tag, "/instr"}, instruction, instr_m);
`ifdef FETCH_SEQUENCER_INSTRET_EN
    check_eq({tag, "/instret"}, instret, retired);
`endif
  endtask

  // One cycle in IDLE; run is set for the next edge.
  task automatic idle_cycle(input string tag, input bit run_val);
    step();
    run = run_val;
    program_counter = pc;
    junk_inputs();
    sample();
    check_static(tag, 1'b1, 1'b0, 2'b00);
  endtask

  task automatic run_instr(input string tag, input int fw, input int ew, input bit taken,
                           input bit wr, input logic [31:0] data, input logic [31:0] off,
                           input bit run_after);
    int total;
    total = fw + ew + 4;
    for (int c = 0; c < total; c++) begin
      bit in_f, in_d, in_e, in_w, done_c;
      in_f   = (c <= fw);
      in_d   = (c == fw + 1);
      in_e   = (c >= fw + 2) && (c <= fw + 2 + ew);
      in_w   = (c == total - 1);
      done_c = (c == fw + 2 + ew);
      step();
      program_counter = pc;
      junk_inputs();
      if (in_f) fetch_ack = (c == fw);
      if (in_f && c == fw) fetch_data = data;
      if (in_e) begin
        execute_done = done_c;
        if (done_c) begin
          branch_taken   = taken;
          register_write = wr;
        end
      end
      run = (in_e || in_w) ? run_after : 1'($urandom_range(0, 1));
      sample();
      check_eq({tag, "/req"},   fetch_request, in_f);
      check_eq({tag, "/addr"},  fetch_address, in_f ? pc : 32'd0);
      check_eq({tag, "/ivld"},  instruction_valid, in_d);
      check_eq({tag, "/adv"},   pc_advance, in_w);
      check_eq({tag, "/br"},    pc_branch, in_w && taken);
      check_eq({tag, "/rwe"},   register_write_enable, in_w && wr);
      check_eq({tag, "/halt"},  halted, 0);
      check_eq({tag, "/fault"}, fault, 0);
      check_eq({tag, "/instr"}, instruction, instr_m);
`ifdef FETCH_SEQUENCER_INSTRET_EN
      check_eq({tag, "/instret"}, instret, retired);
`endif
      if (in_f && c == fw) instr_m = data;
    end
    retired = retired + 64'd1;
    pc = taken ? pc + off : pc + 32'd4;
  endtask

  task automatic do_reset(input string tag);
    step();
    reset = 1'b1;
    run   = 1'b0;
    junk_inputs();
    instr_m = 32'd0;
    retired = 64'd0;
    sample();
    check_static(tag, 1'b1, 1'b0, 2'b00);
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    run = 1'b0;
    fetch_ack = 1'b0;
    fetch_data = 32'd0;
    execute_done = 1'b0;
    branch_taken = 1'b0;
    register_write = 1'b0;
    pc = 32'd0;
    program_counter = 32'd0;
    instr_m = 32'd0;
    retired = 64'd0;
    #3;
    check_static("reset", 1'b1, 1'b0, 2'b00);
    step();
    reset = 1'b0;

    // Zero-wait stream of 0x00000013 from PC 0
    idle_cycle("zw_idle", 1'b1);
    run_instr("zw0", 0, 0, 1'b0, 1'b0, 32'h0000_0013, 32'd0, 1'b1);
    run_instr("zw1", 0, 0, 1'b0, 1'b0, 32'h0000_0013, 32'd0, 1'b1);
    run_instr("zw2", 0, 0, 1'b0, 1'b0, 32'h0000_0013, 32'd0, 1'b0);
    check_eq("zw_pc", pc, 32'd12);
    idle_cycle("zw_stop", 1'b0);

    // Branch taken with register write
    idle_cycle("br_idle", 1'b1);
    run_instr("br", 0, 1, 1'b1, 1'b1, 32'h00A0_0093, 32'h0000_0100, 1'b0);
    idle_cycle("br_stop", 1'b0);

    // Memory stall of 5 cycles at 0x40
    pc = 32'h0000_0040;
    idle_cycle("stall_idle", 1'b1);
    run_instr("stall", 5, 0, 1'b0, 1'b1, 32'h1234_5678, 32'd0, 1'b0);
    idle_cycle("stall_stop", 1'b0);

    // Ack arriving on the last allowed FETCH cycle completes the fetch
    idle_cycle("lim_idle", 1'b1);
    run_instr("lim", TO - 1, 2, 1'b0, 1'b0, 32'hCAFE_0001, 32'd0, 1'b0);
    idle_cycle("lim_stop", 1'b0);

    // Randomized instruction stream
    idle_cycle("rnd_idle", 1'b1);
    for (int i = 0; i < 30; i++) begin
      int  fw, ew;
      bit  tk, wr, ra;
      logic [31:0] off;
      fw  = $urandom_range(0, 8);
      ew  = $urandom_range(0, 5);
      tk  = 1'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      off = 32'($urandom_range(0, 1023)) << 2;
      ra  = (i == 29) ? 1'b0 : ($urandom_range(0, 3) != 0);
      run_instr("rnd", fw, ew, tk, wr, $urandom, off, ra);
      if (!ra && i != 29) begin
        int n;
        n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++) idle_cycle("rnd_pause", 1'b0);
        idle_cycle("rnd_restart", 1'b1);
      end
    end
    idle_cycle("rnd_stop", 1'b0);

    // Fetch timeout: never ack
    pc = 32'h0000_0200;
    idle_cycle("to_idle", 1'b1);
    for (int c = 0; c < TO; c++) begin
      step();
      program_counter = pc;
      junk_inputs();
      fetch_ack = 1'b0;
      sample();
      check_eq("to_req", fetch_request, 1);
      check_eq("to_addr", fetch_address, pc);
      check_eq("to_nofault", fault, 0);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      junk_inputs();
      run = 1'($urandom_range(0, 1));
      sample();
      check_static("to_fault", 1'b0, 1'b1, 2'b10);
    end
    do_reset("to_reset");

    // Misaligned PC when run rises
    pc = 32'h0000_0006;
    idle_cycle("mis_idle", 1'b1);
    for (int c = 0; c < 5; c++) begin
      step();
      junk_inputs();
      run = 1'($urandom_range(0, 1));
      sample();
      check_static("mis_fault", 1'b0, 1'b1, 2'b01);
    end
    do_reset("mis_reset");

    // Build up a retired count, then reset in the middle of a stalled fetch
    pc = 32'h0000_0080;
    idle_cycle("rst_idle", 1'b1);
    run_instr("rst_pre", 0, 0, 1'b0, 1'b1, 32'h0000_0033, 32'd0, 1'b1);
    for (int c = 0; c < 2; c++) begin
      step();
      program_counter = pc;
      junk_inputs();
      fetch_ack = 1'b0;
      sample();
      check_eq("rst_fetch_req", fetch_request, 1);
    end
    step();
    fetch_ack = 1'b0;
    run = 1'b0;
    reset = 1'b1;
    instr_m = 32'd0;
    retired = 64'd0;
    #1;
    check_eq("rst_async_req", fetch_request, 0);
    check_eq("rst_async_addr", fetch_address, 0);
    check_eq("rst_async_halt", halted, 1);
    check_eq("rst_async_instr", instruction, 0);
`ifdef FETCH_SEQUENCER_INSTRET_EN
    check_eq("rst_async_instret", instret, 0);
`endif
    step();
    reset = 1'b0;
    fetch_ack = 1'b1;
    fetch_data = 32'hDEAD_BEEF;
    sample();
    check_static("rst_late_ack", 1'b1, 1'b0, 2'b00);
    step();
    fetch_ack = 1'b1;
    sample();
    check_static("rst_late_ack2", 1'b1, 1'b0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
